// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports, the RAM-side bus and the busy flag.
// The slave modport is the arbiter's view; master is the environment's view.
interface ram_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_dout,
    output a_ack, a_rdata, b_ack, b_rdata,
    output ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_dout,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with registered read data.
// Every grant runs IDLE -> ISSUE -> WAIT -> RESP, one transaction per four cycles.
module ram_arbiter #(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ptrB_q, ptrB_d;
  logic          selB_q, selB_d;
  logic          we_q, we_d;
  logic          ramWe_q, ramWe_d;
  logic [AW-1:0] ramAddr_q, ramAddr_d;
  logic [DW-1:0] ramDin_q, ramDin_d;
  logic [DW-1:0] aRdata_q, aRdata_d;
  logic [DW-1:0] bRdata_q, bRdata_d;
  logic          aAck_q, aAck_d;
  logic          bAck_q, bAck_d;
  logic          grantB;

  // ptrB_q set means port B is preferred when both ports request together.
  assign grantB = bus.b_req && (!bus.a_req || ptrB_q);

  // The RAM address/data registers double as the latched request fields,
  // so they naturally hold their value outside ISSUE and WAIT.
  always_comb begin
    state_d   = state_q;
    ptrB_d    = ptrB_q;
    selB_d    = selB_q;
    we_d      = we_q;
    ramWe_d   = 1'b0;
    ramAddr_d = ramAddr_q;
    ramDin_d  = ramDin_q;
    aRdata_d  = aRdata_q;
    bRdata_d  = bRdata_q;
    aAck_d    = 1'b0;
    bAck_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          selB_d    = grantB;
          ptrB_d    = !grantB;
          we_d      = grantB ? bus.b_we    : bus.a_we;
          ramWe_d   = grantB ? bus.b_we    : bus.a_we;
          ramAddr_d = grantB ? bus.b_addr  : bus.a_addr;
          ramDin_d  = grantB ? bus.b_wdata : bus.a_wdata;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!we_q) begin
          if (selB_q) bRdata_d = bus.ram_dout;
          else        aRdata_d = bus.ram_dout;
        end
        aAck_d  = !selB_q;
        bAck_d  = selB_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptrB_q    <= 1'b0;
      selB_q    <= 1'b0;
      we_q      <= 1'b0;
      ramWe_q   <= 1'b0;
      ramAddr_q <= '0;
      ramDin_q  <= '0;
      aRdata_q  <= '0;
      bRdata_q  <= '0;
      aAck_q    <= 1'b0;
      bAck_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptrB_q    <= ptrB_d;
      selB_q    <= selB_d;
      we_q      <= we_d;
      ramWe_q   <= ramWe_d;
      ramAddr_q <= ramAddr_d;
      ramDin_q  <= ramDin_d;
      aRdata_q  <= aRdata_d;
      bRdata_q  <= bRdata_d;
      aAck_q    <= aAck_d;
      bAck_q    <= bAck_d;
    end
  end

  assign bus.ram_we   = ramWe_q;
  assign bus.ram_addr = ramAddr_q;
  assign bus.ram_din  = ramDin_q;
  assign bus.a_ack    = aAck_q;
  assign bus.b_ack    = bAck_q;
  assign bus.a_rdata  = aRdata_q;
  assign bus.b_rdata  = bRdata_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM plus a transaction-level model of
// round-robin grants, memory contents and per-port read-data registers.
module tb_ram_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [DW-1:0] mem [128] = '{default: '0};
  logic [DW-1:0] shadow [128];
  logic [DW-1:0] expA, expB;
  bit            expPtrB;

  int nAck, nAckA, nAckB, latFirst, latSecond, weTicks;
  bit firstB, dual, timedOut;

  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  ram_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    expA    = '0;
    expB    = '0;
    expPtrB = 1'b0;
  endtask

  task automatic model_txn(input bit portB, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
    if (we)         shadow[addr] = data;
    else if (portB) expB = shadow[addr];
    else            expA = shadow[addr];
    expPtrB = !portB;
  endtask

  // Sole requester wins; on a tie the preferred port goes first.
  task automatic model_pair(input bit ra, rb, wa, wb, input logic [AW-1:0] aa, ab,
                            input logic [DW-1:0] da, db, output bit fB);
    fB = (ra && rb) ? expPtrB : rb;
    if (fB) model_txn(1'b1, wb, ab, db);
    else    model_txn(1'b0, wa, aa, da);
    if (ra && rb) begin
      if (fB) model_txn(1'b0, wa, aa, da);
      else    model_txn(1'b1, wb, ab, db);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one or two requests, holding each req until its ack, and records what happened.
  task automatic run_pair(input bit ra, rb, wa, wb, input logic [AW-1:0] aa, ab,
                          input logic [DW-1:0] da, db);
    int cyc = 0;
    bit doneA, doneB;
    doneA = !ra; doneB = !rb;
    nAck = 0; nAckA = 0; nAckB = 0; latFirst = 0; latSecond = 0; weTicks = 0;
    firstB = 0; dual = 0; timedOut = 0;
    bus.a_req = ra; bus.a_we = wa; bus.a_addr = aa; bus.a_wdata = da;
    bus.b_req = rb; bus.b_we = wb; bus.b_addr = ab; bus.b_wdata = db;
    while (!(doneA && doneB) && !timedOut) begin
      tick();
      cyc++;
      if (bus.ram_we) weTicks++;
      if (bus.a_ack && bus.b_ack) dual = 1;
      if (bus.a_ack || bus.b_ack) begin
        if (nAck == 0) begin latFirst = cyc; firstB = bus.b_ack; end
        else latSecond = cyc;
        nAck++;
      end
      if (bus.a_ack) begin nAckA++; doneA = 1; bus.a_req = 1'b0; end
      if (bus.b_ack) begin nAckB++; doneB = 1; bus.b_req = 1'b0; end
      if (cyc >= 40) timedOut = 1;
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
    if (bus.a_ack || bus.b_ack) nAck++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %0d expected 0", bus.busy); end
    vectors++; if (bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ram_we: got %0d expected 0", bus.ram_we); end
    vectors++; if (bus.ram_addr !== 7'd0 || bus.ram_din !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_ram_bus: got addr %0h din %0h expected 0 0", bus.ram_addr, bus.ram_din); end
    vectors++; if ({bus.a_ack, bus.b_ack} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_acks: got %b expected 00", {bus.a_ack, bus.b_ack}); end
    vectors++; if (bus.a_rdata !== 8'd0 || bus.b_rdata !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_rdata: got %0h/%0h expected 0/0", bus.a_rdata, bus.b_rdata); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    int weSeen = 0, busySeen = 0, ackSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ram_we) weSeen++;
      if (bus.busy) busySeen++;
      if (bus.a_ack || bus.b_ack) ackSeen++;
    end
    vectors++; if (weSeen !== 0) begin miscompares++; $display("[TB] FAIL idle_we: got %0d cycles expected 0", weSeen); end
    vectors++; if (busySeen !== 0) begin miscompares++; $display("[TB] FAIL idle_busy: got %0d cycles expected 0", busySeen); end
    vectors++; if (ackSeen !== 0) begin miscompares++; $display("[TB] FAIL idle_ack: got %0d acks expected 0", ackSeen); end
  endtask

  task automatic test_write_read();
    bit fB;
    run_pair(1'b1, 1'b0, 1'b1, 1'b0, 7'd10, 7'd0, 8'hAA, 8'h00);
    model_pair(1'b1, 1'b0, 1'b1, 1'b0, 7'd10, 7'd0, 8'hAA, 8'h00, fB);
    vectors++; if (nAck !== 1 || nAckA !== 1) begin miscompares++; $display("[TB] FAIL wr_acks: got %0d/%0d expected 1/1", nAck, nAckA); end
    vectors++; if (latFirst !== 3) begin miscompares++; $display("[TB] FAIL wr_latency: got %0d expected 3", latFirst); end
    vectors++; if (weTicks !== 1) begin miscompares++; $display("[TB] FAIL wr_we_pulse: got %0d expected 1", weTicks); end
    run_pair(1'b1, 1'b0, 1'b0, 1'b0, 7'd10, 7'd0, 8'h3C, 8'h00);
    model_pair(1'b1, 1'b0, 1'b0, 1'b0, 7'd10, 7'd0, 8'h3C, 8'h00, fB);
    vectors++; if (latFirst !== 3 || nAck !== 1) begin miscompares++; $display("[TB] FAIL rd_latency: got %0d (acks %0d) expected 3 (1)", latFirst, nAck); end
    vectors++; if (weTicks !== 0) begin miscompares++; $display("[TB] FAIL rd_we: got %0d expected 0", weTicks); end
    vectors++; if (bus.a_rdata !== expA) begin miscompares++; $display("[TB] FAIL rd_a_rdata: got %0h expected %0h", bus.a_rdata, expA); end
    vectors++; if (bus.b_rdata !== expB) begin miscompares++; $display("[TB] FAIL rd_b_rdata: got %0h expected %0h", bus.b_rdata, expB); end
    vectors++; if (bus.ram_addr !== 7'd10) begin miscompares++; $display("[TB] FAIL addr_hold: got %0d expected 10", bus.ram_addr); end
  endtask

  task automatic test_simultaneous();
    bit fB;
    do_reset();
    run_pair(1'b1, 1'b1, 1'b1, 1'b0, 7'd20, 7'd20, 8'h55, 8'h99);
    model_pair(1'b1, 1'b1, 1'b1, 1'b0, 7'd20, 7'd20, 8'h55, 8'h99, fB);
    vectors++; if (nAck !== 2) begin miscompares++; $display("[TB] FAIL sim_acks: got %0d expected 2", nAck); end
    vectors++; if (firstB !== fB) begin miscompares++; $display("[TB] FAIL sim_first: got B=%0d expected B=%0d", firstB, fB); end
    vectors++; if (dual !== 1'b0) begin miscompares++; $display("[TB] FAIL sim_dual_ack: got %0d expected 0", dual); end
    vectors++; if (latSecond !== 7) begin miscompares++; $display("[TB] FAIL sim_second_latency: got %0d expected 7", latSecond); end
    vectors++; if (bus.b_rdata !== expB) begin miscompares++; $display("[TB] FAIL sim_b_rdata: got %0h expected %0h", bus.b_rdata, expB); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] aAddr, bAddr;
    int acks = 0, cntA = 0, cntB = 0, busyLow = 0, dualSeen = 0, cyc = 0;
    bit wantB;
    do_reset();
    aAddr = 7'($urandom_range(0, 15));
    bAddr = 7'($urandom_range(0, 15));
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = aAddr; bus.a_wdata = 8'h00;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = bAddr; bus.b_wdata = 8'h00;
    while (acks < 8 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.a_ack && bus.b_ack) dualSeen++;
      if (bus.a_ack || bus.b_ack) begin
        wantB = expPtrB;
        vectors++;
        if (bus.b_ack !== wantB) begin miscompares++; $display("[TB] FAIL b2b_order: ack %0d got B=%0d expected B=%0d", acks, bus.b_ack, wantB); end
        if (bus.b_ack) cntB++; else cntA++;
        model_txn(wantB, 1'b0, wantB ? bAddr : aAddr, 8'h00);
        acks++;
      end else if (acks > 0 && !bus.busy) begin
        busyLow++;
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
    vectors++; if (cntA !== 4 || cntB !== 4) begin miscompares++; $display("[TB] FAIL b2b_counts: got A=%0d B=%0d expected 4/4", cntA, cntB); end
    vectors++; if (busyLow !== 7) begin miscompares++; $display("[TB] FAIL b2b_busy_gaps: got %0d expected 7", busyLow); end
    vectors++; if (dualSeen !== 0) begin miscompares++; $display("[TB] FAIL b2b_dual_ack: got %0d expected 0", dualSeen); end
    vectors++; if (bus.a_rdata !== expA || bus.b_rdata !== expB) begin miscompares++; $display("[TB] FAIL b2b_rdata: got %0h/%0h expected %0h/%0h", bus.a_rdata, bus.b_rdata, expA, expB); end
  endtask

  task automatic test_req_drop();
    logic [DW-1:0] v;
    bit fB;
    int bAcks = 0, aAcks = 0;
    v = 8'($urandom_range(1, 255));
    run_pair(1'b1, 1'b0, 1'b1, 1'b0, 7'd127, 7'd0, v, 8'h00);
    model_pair(1'b1, 1'b0, 1'b1, 1'b0, 7'd127, 7'd0, v, 8'h00, fB);
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'd127; bus.b_wdata = 8'($urandom);
    tick();
    bus.b_req = 1'b0;
    bus.b_we = 1'b1;
    bus.b_addr = 7'($urandom_range(0, 126));
    model_txn(1'b1, 1'b0, 7'd127, 8'h00);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.b_ack) bAcks++;
      if (bus.a_ack) aAcks++;
    end
    vectors++; if (bAcks !== 1 || aAcks !== 0) begin miscompares++; $display("[TB] FAIL drop_acks: got B=%0d A=%0d expected 1/0", bAcks, aAcks); end
    vectors++; if (bus.b_rdata !== expB) begin miscompares++; $display("[TB] FAIL drop_b_rdata: got %0h expected %0h", bus.b_rdata, expB); end
    vectors++; if (bus.a_rdata !== expA) begin miscompares++; $display("[TB] FAIL drop_a_rdata: got %0h expected %0h", bus.a_rdata, expA); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_busy: got %0d expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] addr;
    logic [DW-1:0] v;
    bit fB;
    int lat = 0;
    addr = 7'($urandom_range(0, 126));
    v = 8'($urandom_range(1, 255));
    run_pair(1'b1, 1'b0, 1'b1, 1'b0, addr, 7'd0, v, 8'h00);
    model_pair(1'b1, 1'b0, 1'b1, 1'b0, addr, 7'd0, v, 8'h00, fB);
    run_pair(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, addr, 8'h00, 8'h00);
    model_pair(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, addr, 8'h00, 8'h00, fB);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = addr; bus.a_wdata = 8'h00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (bus.a_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_ack: got %0d expected 0", bus.a_ack); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_busy: got %0d expected 0", bus.busy); end
    vectors++; if (bus.a_rdata !== 8'd0 || bus.b_rdata !== 8'd0) begin miscompares++; $display("[TB] FAIL mid_rst_rdata: got %0h/%0h expected 0/0", bus.a_rdata, bus.b_rdata); end
    vectors++; if (bus.ram_addr !== 7'd0 || bus.ram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_ram: got addr %0d we %0d expected 0 0", bus.ram_addr, bus.ram_we); end
    rst = 1'b0;
    model_reset();
    while (!bus.a_ack && lat < 10) begin
      tick();
      lat++;
    end
    bus.a_req = 1'b0;
    model_txn(1'b0, 1'b0, addr, 8'h00);
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL mid_regrant_latency: got %0d expected 3", lat); end
    vectors++; if (bus.a_rdata !== expA) begin miscompares++; $display("[TB] FAIL mid_regrant_rdata: got %0h expected %0h", bus.a_rdata, expA); end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] sel;
    bit ra, rb, wa, wb, fB;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    int expN, expWe;
    for (int it = 0; it < 40; it++) begin
      sel = 2'($urandom_range(1, 3));
      ra = sel[0]; rb = sel[1];
      wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
      aa = (it % 5 == 0) ? 7'd127 : 7'($urandom_range(0, 15));
      ab = 7'($urandom_range(0, 15));
      da = 8'($urandom); db = 8'($urandom);
      run_pair(ra, rb, wa, wb, aa, ab, da, db);
      model_pair(ra, rb, wa, wb, aa, ab, da, db, fB);
      expN = int'(ra) + int'(rb);
      expWe = int'(ra && wa) + int'(rb && wb);
      vectors++; if (nAck !== expN || dual !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_acks: it %0d got %0d (dual %0d) expected %0d", it, nAck, dual, expN); end
      vectors++; if (firstB !== fB) begin miscompares++; $display("[TB] FAIL rnd_order: it %0d got B=%0d expected B=%0d", it, firstB, fB); end
      vectors++; if (weTicks !== expWe) begin miscompares++; $display("[TB] FAIL rnd_we: it %0d got %0d expected %0d", it, weTicks, expWe); end
      vectors++; if (latFirst !== 3) begin miscompares++; $display("[TB] FAIL rnd_latency: it %0d got %0d expected 3", it, latFirst); end
      vectors++; if (bus.a_rdata !== expA || bus.b_rdata !== expB) begin miscompares++; $display("[TB] FAIL rnd_rdata: it %0d got %0h/%0h expected %0h/%0h", it, bus.a_rdata, bus.b_rdata, expA, expB); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    for (int i = 0; i < 128; i++) shadow[i] = '0;
    model_reset();
    test_reset();
    test_idle();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: AW, 7, address width (128-word RAM).
REQ-002 Parameter: DW, 8, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a_req  input  1  port A request; held high until a_ack.
REQ-006 a_we  input  1  port A write (1) / read (0); sampled with a_req.
REQ-007 a_addr  input  AW  port A word address.
REQ-008 a_wdata  input  DW  port A write data.
REQ-009 a_ack  output  1  one-cycle pulse; port A transaction complete.
REQ-010 a_rdata  output  DW  port A read data; valid from a_ack, held until the next port A read completes.
REQ-011 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: port B, identical to REQ-005..REQ-010.
REQ-012 ram_we  output  1  RAM write enable.
REQ-013 ram_addr  output  AW  RAM address.
REQ-014 ram_din  output  DW  RAM write data.
REQ-015 ram_dout  input  DW  RAM read data, registered: valid one cycle after ram_addr is presented.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; the FSM leaves IDLE only when a_req or b_req is high.
REQ-018 IDLE: select a winner, latch its we/addr/wdata and its port id, then go to ISSUE; with no request, stay in IDLE.
REQ-019 Arbitration: round-robin pointer names the preferred port.
- Sole requester always wins.
- On a simultaneous request, the preferred port wins.
- After each grant, the pointer moves to the non-granted port.
REQ-020 ISSUE (1 cycle): ram_addr/ram_din = latched values; ram_we = latched we; then go to WAIT.
REQ-021 WAIT (1 cycle): ram_we = 0, ram_addr held.
- On a read, ram_dout is captured into the winner's rdata register at the end of WAIT.
- Then go to RESP.
REQ-022 RESP (1 cycle): the winner's ack = 1; then go to IDLE.
REQ-023 Timing: request sampled at edge E0 gives ISSUE in cycle 1, WAIT in cycle 2, ack in cycle 3, IDLE in cycle 4; throughput is 1 transaction per 4 cycles.
REQ-024 ram_we SHALL be high only in ISSUE, and only for a write.
REQ-025 Outside ISSUE/WAIT, ram_addr and ram_din SHALL hold their last values.
REQ-026 A write SHALL NOT modify either rdata register; the write still returns an ack.
REQ-027 The losing port's req stays pending, without loss, and is served in the next arbitration.
REQ-028 Inputs of the granted port are latched; changes to them, or deassertion of req, after the grant SHALL NOT affect the transaction, and the ack still pulses.
REQ-029 If req is still high during that port's ack cycle, it counts as a new request at the next IDLE.
REQ-030 Exactly one ack at most per cycle; a_ack and b_ack SHALL never be high together.
REQ-031 Only the granting port's rdata register is updated; the other port's rdata is unchanged.

Reset
REQ-032 When rst is high at an edge, the outputs after that edge SHALL be as follows, regardless of current state:
- state = IDLE;
- ram_we = 0, ram_addr = 0, ram_din = 0;
- a_ack = b_ack = 0, a_rdata = b_rdata = 0;
- busy = 0;
- round-robin pointer = port A.
REQ-033 Reset mid-transaction aborts it:
- no ack is issued;
- a write aborted in ISSUE may already have been written;
- a pending req is re-arbitrated after rst falls.
REQ-034 The first cycle with rst low SHALL be IDLE and may accept a request.

Verification
REQ-035 A writes 0xAA to addr 10, then reads addr 10 -> ram_we high exactly 1 cycle; a_ack in cycle 3 of each transaction; a_rdata = 0xAA; b_rdata = 0x00.
REQ-036 a_req and b_req rise together after reset (A: write 0x55 @20, B: read @20) -> A granted first, B second; b_rdata = 0x55; exactly 2 acks, never simultaneous.
REQ-037 Both ports hold req continuously for 8 transactions -> grants alternate A,B,A,B...; each port receives 4 acks; busy low for exactly 1 cycle between transactions.
REQ-038 B reads addr 127, and b_req drops in the ISSUE cycle -> the transaction completes, b_ack pulses once, b_rdata = RAM[127]; b_addr changes after the grant are ignored.
REQ-039 rst asserted during the WAIT of an A read -> next cycle IDLE, no a_ack, a_rdata = 0, busy = 0; with a_req still high, A is re-granted and completes normally.
REQ-040 Idle bench (no req) for 20 cycles -> ram_we = 0, busy = 0, no acks.
